// File: rtl/regfile_pkg.sv
// Shared widths and operand types for the register file and its read ports.
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_NUM_REGS = 1 << DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: storage lookup with write-to-read bypass,
// busy lookup from the scoreboard, and the hard-wired zero register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic [DATA_W-1:0]   regs_i [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy_i,
    input  logic [ADDR_W-1:0]   select_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                busy_o
);

    // Resolve operand: zero register first, then bypass, else storage.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path through the block leaves a latch behind.
        data_o = regs_i[select_i];
        busy_o = busy_i[select_i];
        if (ZERO_REG && (select_i == '0)) begin
            data_o = '0;
            busy_o = 1'b0;
        end else if (wr_en_i && (wr_addr_i == select_i)) begin
            // The writeback value arrives this cycle, so the operand is ready.
            data_o = wr_data_i;
            busy_o = 1'b0;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file_sb.sv
// Register file with one write port, two bypassed read ports (x, y) and a
// per-register busy scoreboard tracking in-flight producers.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] x_select,
    input  logic [ADDR_W-1:0] y_select,
    output logic [DATA_W-1:0] x_data,
    output logic [DATA_W-1:0] y_data,
    output logic              x_busy,
    output logic              y_busy
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic wr_allowed;
    logic rsv_allowed;

    // Address 0 is inert for writes and reserves when it is the zero register.
    assign wr_allowed  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
    assign rsv_allowed = rsv_en && !(ZERO_REG && (rsv_addr == '0)) && !flush;

    // Next state: write clears busy, a reserve then sets it (new producer wins),
    // and a flush clears every busy bit while still letting the write land.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_allowed) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_allowed) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // State registers with synchronous reset overriding all other requests.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the storage array is reset explicitly because software
            // relies on registers reading 0 after reset; this keeps it in flops.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG)
    ) u_port_x (
        .regs_i   (regs_q),
        .busy_i   (busy_q),
        .select_i (x_select),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .data_o   (x_data),
        .busy_o   (x_busy)
    );

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG)
    ) u_port_y (
        .regs_i   (regs_q),
        .busy_i   (busy_q),
        .select_i (y_select),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .data_o   (y_data),
        .busy_o   (y_busy)
    );

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: a general instance (ZERO_REG=0) and a
// zero-register instance (ZERO_REG=1) share all inputs.
module tb_register_file_sb;
    import regfile_pkg::*;

    logic      clock = 1'b0;
    logic      reset;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    logic      rsv_en;
    reg_addr_t rsv_addr;
    logic      flush;
    reg_addr_t x_select;
    reg_addr_t y_select;
    reg_data_t x_data, y_data, zx_data, zy_data;
    logic      x_busy, y_busy, zx_busy, zy_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    register_file_sb #(.ZERO_REG(1'b0)) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .x_select(x_select), .y_select(y_select),
        .x_data(x_data), .y_data(y_data), .x_busy(x_busy), .y_busy(y_busy)
    );

    register_file_sb #(.ZERO_REG(1'b1)) dut_z (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .x_select(x_select), .y_select(y_select),
        .x_data(zx_data), .y_data(zy_data), .x_busy(zx_busy), .y_busy(zy_busy)
    );

    typedef struct {
        logic      wr_en;
        reg_addr_t wr_addr;
        reg_data_t wr_data;
        logic      rsv_en;
        reg_addr_t rsv_addr;
        logic      flush;
        reg_addr_t x_sel;
        reg_addr_t y_sel;
        reg_data_t exp_x;
        reg_data_t exp_y;
        logic      exp_xb;
        logic      exp_yb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1; x_select = '0; y_select = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        // Reset state on both instances.
        for (int i = 0; i < 8; i++) begin
            x_select = reg_addr_t'(i); y_select = reg_addr_t'(i);
            #1;
            check($sformatf("rst_x_data_r%0d", i), x_data, 16'h0000);
            check($sformatf("rst_y_busy_r%0d", i), {15'b0, y_busy}, 16'h0000);
        end

        // Test 1: write R3, then reset (overriding a write and a reserve).
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        tick();
        idle(); x_select = 3'd3;
        #1;
        check("t1_pre_reset_r3", x_data, 16'h1234);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h5555;
        rsv_en = 1'b1; rsv_addr = 3'd3; flush = 1'b0;
        tick();
        reset = 1'b0; idle(); x_select = 3'd3;
        #1;
        check("t1_x_data_r3", x_data, 16'h0000);
        check("t1_x_busy_r3", {15'b0, x_busy}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            x_select = reg_addr_t'(i); y_select = reg_addr_t'(i);
            #1;
            check($sformatf("t1_all_x_r%0d", i), x_data, 16'h0000);
            check($sformatf("t1_all_zy_r%0d", i), zy_data, 16'h0000);
        end

        // Directed table for the general instance.
        //                wr  wa    wd        rv  ra    fl  xs    ys    ex        ey        xb  yb
        vecs.push_back('{1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd2, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd5, 3'd2, 16'hBEEF, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'd2, 16'h0042, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2, 16'h0042, 16'h0042, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2, 16'h0042, 16'h0042, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd4, 16'h00AA, 1'b1, 3'd4, 1'b0, 3'd4, 3'd3, 16'h00AA, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4, 16'h00AA, 16'h00AA, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 3'd1, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 1'b0, 3'd1, 3'd6, 16'h0000, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 16'h0011, 1'b1, 3'd7, 1'b1, 3'd1, 3'd6, 16'h0011, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd1, 3'd6, 16'h0011, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd7, 3'd4, 16'h0000, 16'h00AA, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 16'h7777, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 16'h7777, 16'h7777, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b0, 3'd0, 3'd3, 16'h7777, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 16'h7777, 16'h7777, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 3'd3, 16'h1357, 1'b0, 3'd0, 1'b0, 3'd3, 3'd4, 16'h1357, 16'h00AA, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 16'h2468, 1'b0, 3'd0, 1'b0, 3'd3, 3'd0, 16'h1357, 16'h2468, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr; flush = vecs[i].flush;
            x_select = vecs[i].x_sel; y_select = vecs[i].y_sel;
            #1;
            check($sformatf("vec%0d_x_data", i), x_data, vecs[i].exp_x);
            check($sformatf("vec%0d_y_data", i), y_data, vecs[i].exp_y);
            check($sformatf("vec%0d_x_busy", i), {15'b0, x_busy}, {15'b0, vecs[i].exp_xb});
            check($sformatf("vec%0d_y_busy", i), {15'b0, y_busy}, {15'b0, vecs[i].exp_yb});
            tick();
        end

        // Test 6: zero register ignores write + reserve; general instance does not.
        idle();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 3'd0;
        x_select = 3'd0; y_select = 3'd0;
        #1;
        check("t6_z_x_data_same", zx_data, 16'h0000);
        check("t6_z_x_busy_same", {15'b0, zx_busy}, 16'h0000);
        check("t6_z_y_data_same", zy_data, 16'h0000);
        check("t6_g_x_data_same", x_data, 16'hFFFF);
        tick();
        idle(); x_select = 3'd0; y_select = 3'd5;
        #1;
        check("t6_z_x_data_next", zx_data, 16'h0000);
        check("t6_z_x_busy_next", {15'b0, zx_busy}, 16'h0000);
        check("t6_z_y_data_r5", zy_data, 16'hBEEF);
        check("t6_g_x_data_next", x_data, 16'hFFFF);
        check("t6_g_x_busy_next", {15'b0, x_busy}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file_sb
